seq_divider: RTL and testbench

SEQ_DIVIDER -- requirements
Module: seq_divider

---
 rtl/seq_arith_pkg.sv | 13 +
 rtl/seq_divider_div_step.sv | 32 +++
 rtl/seq_divider.sv | 116 +++++++++++
 tb/tb_seq_divider.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/seq_arith_pkg.sv
// Shared types and constants for the sequential arithmetic units
// (divider and multiplier).
package seq_arith_pkg;

  localparam int WIDTH_DEF = 16;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FINISH
  } state_t;

endpackage

// File: rtl/seq_divider_div_step.sv
// One restoring-division iteration: shift {A,Q} left, trial-subtract D,
// and keep the difference only when it does not go negative.
module div_step
  import seq_arith_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic [WIDTH:0]   a,
  input  logic [WIDTH-1:0] q,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH:0]   a_next,
  output logic [WIDTH-1:0] q_next
);

  logic [WIDTH+1:0] a_sh;
  logic [WIDTH+1:0] trial;

  // One extra bit so the MSB of the trial is a true sign bit.
  assign a_sh  = {a, q[WIDTH-1]};
  assign trial = a_sh - {2'b00, d};

  always_comb begin
    if (!trial[WIDTH+1]) begin
      a_next = trial[WIDTH:0];
      q_next = {q[WIDTH-2:0], 1'b1};
    end else begin
      a_next = a_sh[WIDTH:0];
      q_next = {q[WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle unsigned restoring divider: WIDTH iterations per division,
// results registered and announced with a one-cycle done pulse.
module seq_divider
  import seq_arith_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH + 1);

  state_t           state, state_n;
  logic [WIDTH:0]   a_q, a_n, step_a;
  logic [WIDTH-1:0] q_q, q_n, step_q;
  logic [WIDTH-1:0] d_q, d_n;
  logic [CW-1:0]    cnt, cnt_n;
  logic [WIDTH-1:0] quo_n, rem_n;
  logic             dbz_n, done_n;

  div_step #(.WIDTH(WIDTH)) u_step (
    .a      (a_q),
    .q      (q_q),
    .d      (d_q),
    .a_next (step_a),
    .q_next (step_q)
  );

  assign busy = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q         <= '0;
      q_q         <= '0;
      d_q         <= '0;
      cnt         <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      done        <= 1'b0;
    end else begin
      a_q         <= a_n;
      q_q         <= q_n;
      d_q         <= d_n;
      cnt         <= cnt_n;
      quotient    <= quo_n;
      remainder   <= rem_n;
      div_by_zero <= dbz_n;
      done        <= done_n;
    end
  end

  always_comb begin
    state_n = state;
    a_n     = a_q;
    q_n     = q_q;
    d_n     = d_q;
    cnt_n   = cnt;
    quo_n   = quotient;
    rem_n   = remainder;
    dbz_n   = div_by_zero;
    done_n  = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          q_n     = dividend;
          d_n     = divisor;
          a_n     = '0;
          cnt_n   = '0;
          state_n = (divisor == '0) ? FINISH : RUN;
        end
      end
      RUN: begin
        a_n   = step_a;
        q_n   = step_q;
        cnt_n = cnt + 1'b1;
        if (cnt == CW'(WIDTH - 1)) state_n = FINISH;
      end
      FINISH: begin
        // A zero divisor idles one cycle here so its result lands two
        // edges after the accepting edge.
        if (d_q == '0 && cnt == '0) begin
          cnt_n = CW'(1);
        end else begin
          done_n  = 1'b1;
          state_n = IDLE;
          if (d_q == '0) begin
            quo_n = '1;
            rem_n = q_q;
            dbz_n = 1'b1;
          end else begin
            quo_n = q_q;
            rem_n = a_q[WIDTH-1:0];
            dbz_n = 1'b0;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_seq_divider.sv
// Scoreboard bench for seq_divider: expected results are queued when a
// request is accepted and compared, with latency, on each done pulse.
module tb_seq_divider;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] dividend = '0;
  logic [W-1:0] divisor = '0;
  logic         busy, done, div_by_zero;
  logic [W-1:0] quotient, remainder;

  seq_divider #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         z;
    int           due;
  } exp_t;

  exp_t sb[$];
  exp_t last;
  int   errors = 0, checks = 0, cyc = 0, done_cnt = 0, n_exp = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input int due);
    exp_t e;
    if (b == '0) begin
      e.q = '1; e.r = a; e.z = 1'b1;
    end else begin
      e.q = a / b; e.r = a % b; e.z = 1'b0;
    end
    e.due = due;
    return e;
  endfunction

  always @(posedge clk) cyc++;

  // Monitor: results on done, held values otherwise.
  always @(negedge clk) begin
    if (!rst) begin
      if (done) begin
        done_cnt++;
        if (sb.size() == 0) begin
          chk("spurious_done", 1, 0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("quotient", quotient, e.q);
          chk("remainder", remainder, e.r);
          chk("div_by_zero", div_by_zero, e.z);
          chk("latency", cyc, e.due);
          last = e;
        end
      end else begin
        chk("hold", {quotient, remainder, div_by_zero}, {last.q, last.r, last.z});
      end
    end
  end

  // Hold start with the operands until the divider accepts them.
  task automatic drive(input logic [W-1:0] a, input logic [W-1:0] b);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 60 && !ok; i++) begin
      @(negedge clk);
      start = 1'b1; dividend = a; divisor = b;
      if (!busy) begin
        sb.push_back(model(a, b, cyc + 1 + ((b == '0) ? 2 : W + 1)));
        n_exp++;
        ok = 1'b1;
      end
      @(posedge clk);
    end
    #1 start = 1'b0;
    if (!ok) chk("accept_timeout", 0, 1);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 100 && sb.size() != 0; i++) @(negedge clk);
    @(negedge clk);
    chk("drain", sb.size(), 0);
  endtask

  initial begin
    #400000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    last = '{q: '0, r: '0, z: 1'b0, due: 0};
    #12;
    chk("rst_outputs", {busy, done, quotient, remainder, div_by_zero}, '0);
    @(negedge clk) rst = 1'b0;

    drive(16'd100, 16'd7);
    wait_idle();
    drive(16'hFFFF, 16'd1);
    drive(16'd3, 16'd10);
    wait_idle();
    drive(16'd5, 16'd0);
    wait_idle();

    // Second request is ignored while busy and taken in the done cycle.
    drive(16'd50, 16'd5);
    drive(16'd9, 16'd2);
    wait_idle();

    drive(16'd0, 16'hFFFF);
    drive(16'hFFFF, 16'hFFFF);
    drive(16'h8000, 16'h8001);
    drive(16'hFFFF, 16'd0);
    wait_idle();

    for (int i = 0; i < 6; i++) begin
      logic [W-1:0] ra, rb;
      ra = W'($urandom);
      rb = (i == 3) ? '0 : W'($urandom_range(1, 2 ** W - 1));
      drive(ra, rb);
    end
    wait_idle();

    // Abort mid-division: outputs clear at once and no done follows.
    drive(16'd1000, 16'd3);
    repeat (8) @(posedge clk);
    #3 rst = 1'b1;
    #1 chk("rst_abort", {busy, done, quotient, remainder, div_by_zero}, '0);
    n_exp -= sb.size();
    sb.delete();
    last = '{q: '0, r: '0, z: 1'b0, due: 0};
    @(negedge clk) rst = 1'b0;
    repeat (25) @(negedge clk);
    drive(16'd1000, 16'd3);
    wait_idle();

    chk("done_count", done_cnt, n_exp);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
